// File: rtl/pixel_window_gen.sv
// Framebuffer-to-RGB pixel generator: windowed, power-of-2 upscaled reads with border fill and test patterns.
// Latency: read address one pixel ahead, colour one cycle after coordinates; no backpressure (pixel-clock paced).
module pixel_window_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int WIN_X0     = 0,
    parameter int WIN_Y0     = 40,
    parameter int WIN_W      = 640,
    parameter int WIN_H      = 400,
    parameter int LOG2_SCALE = 0,
    parameter int ADDR_W     = 18,
    parameter int PIX_FMT    = 0,
    parameter int BAR_SHIFT  = 6
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [9:0]        iCoordX,
    input  logic [9:0]        iCoordY,
    input  logic [15:0]       iData,
    input  logic [1:0]        iMode,
    input  logic [11:0]       iBorder,
    output logic [ADDR_W-1:0] oNext_Addr,
    output logic              oRd_En,
    output logic [3:0]        oRed,
    output logic [3:0]        oGreen,
    output logic [3:0]        oBlue,
    output logic              oVIDEO_ON
);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        MODE_FB    = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_CHECK = 2'b10,
        MODE_SOLID = 2'b11
    } mode_e;

    localparam int                FB_W       = WIN_W >> LOG2_SCALE;
    localparam logic [9:0]        H_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0]        V_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [9:0]        X0         = 10'(WIN_X0);
    localparam logic [9:0]        Y0         = 10'(WIN_Y0);
    localparam logic [10:0]       X1         = 11'(WIN_X0 + WIN_W);
    localparam logic [10:0]       Y1         = 11'(WIN_Y0 + WIN_H);
    localparam logic [9:0]        SCALE_MASK = 10'((1 << LOG2_SCALE) - 1);
    localparam logic [ADDR_W-1:0] FB_STEP    = ADDR_W'(FB_W);

    function automatic logic inWin(input logic [9:0] a, input logic [9:0] b);
        return (a >= X0) && ({1'b0, a} < X1) && (b >= Y0) && ({1'b0, b} < Y1);
    endfunction

    mode_e             modeQ;
    logic              synced;
    logic [ADDR_W-1:0] rowBase;
    rgb_t              colourQ;

    logic              lineEnd;
    logic              frameEnd;
    logic [9:0]        nx;
    logic [9:0]        ny;
    logic [9:0]        relNx;
    logic [9:0]        relNy;
    logic [9:0]        relX;
    logic [9:0]        relY;
    logic              rowStep;
    logic              syncedNext;
    logic [ADDR_W-1:0] rowBaseNext;
    logic [ADDR_W-1:0] addrNext;
    logic              rdNext;

    // Next-pixel coordinate and the incrementally maintained row base for line ny.
    always_comb begin
        lineEnd     = (iCoordX == H_LAST);
        frameEnd    = lineEnd && (iCoordY == V_LAST);
        nx          = lineEnd ? 10'd0 : iCoordX + 10'd1;
        ny          = frameEnd ? 10'd0 : (lineEnd ? iCoordY + 10'd1 : iCoordY);
        relNx       = nx - X0;
        relNy       = ny - Y0;
        rowStep     = lineEnd && !frameEnd && (ny > Y0) && ({1'b0, ny} < Y1)
                      && ((relNy & SCALE_MASK) == 10'd0);
        rowBaseNext = rowBase;
        if (frameEnd) begin
            rowBaseNext = '0;
        end else if (rowStep) begin
            rowBaseNext = rowBase + FB_STEP;
        end
        syncedNext  = synced | frameEnd;
        rdNext      = syncedNext && inWin(nx, ny);
        addrNext    = '0;
        if (rdNext) begin
            addrNext = rowBaseNext + ADDR_W'(relNx >> LOG2_SCALE);
        end
    end

    rgb_t       fbColour;
    rgb_t       colourNext;
    logic       videoNext;
    logic [2:0] bar;

    always_comb begin
        relX = iCoordX - X0;
        relY = iCoordY - Y0;
        bar  = 3'(relX >> BAR_SHIFT);
        if (PIX_FMT == 1) begin
            fbColour = '{r: iData[15:12], g: iData[10:7], b: iData[4:1]};
        end else begin
            fbColour = '{r: iData[11:8], g: iData[7:4], b: iData[3:0]};
        end
        colourNext = rgb_t'(iBorder);
        videoNext  = 1'b0;
        if (synced && inWin(iCoordX, iCoordY) && (modeQ != MODE_SOLID)) begin
            videoNext = 1'b1;
            case (modeQ)
                MODE_FB:    colourNext = fbColour;
                MODE_BARS:  colourNext = '{r: {4{bar[2]}}, g: {4{bar[1]}}, b: {4{bar[0]}}};
                MODE_CHECK: colourNext = (relX[4] ^ relY[4]) ? 12'hFFF : 12'h000;
                default:    colourNext = rgb_t'(iBorder);
            endcase
        end
    end

    // Mode and sync only change on the frame boundary so a frame is never mixed.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            modeQ      <= MODE_FB;
            synced     <= 1'b0;
            rowBase    <= '0;
            oNext_Addr <= '0;
            oRd_En     <= 1'b0;
            colourQ    <= '0;
            oVIDEO_ON  <= 1'b0;
        end else begin
            rowBase    <= rowBaseNext;
            synced     <= syncedNext;
            if (frameEnd) begin
                modeQ <= mode_e'(iMode);
            end
            oNext_Addr <= addrNext;
            oRd_En     <= rdNext;
            colourQ    <= colourNext;
            oVIDEO_ON  <= videoNext;
        end
    end

    assign oRed   = colourQ.r;
    assign oGreen = colourQ.g;
    assign oBlue  = colourQ.b;

    logic unusedBits;
    assign unusedBits = ^{iData, relX, relY, relNx, relNy};

endmodule

// File: tb/tb_pixel_window_gen.sv
// Directed bench: four parameterisations driven by one coordinate stream; memory model returns addr[11:0].
module tb_pixel_window_gen;

    logic        iCLK;
    logic        iRST_N;
    logic [9:0]  iCoordX;
    logic [9:0]  iCoordY;
    logic [1:0]  iMode;
    logic [11:0] iBorder;
    logic        constEn;
    logic [15:0] constData;

    logic [17:0] addr0, addr1, addr2, addr3;
    logic        rd0, rd1, rd2, rd3;
    logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2, r3, g3, b3;
    logic        vid0, vid1, vid2, vid3;
    logic [15:0] data0, data1, data2, data3;
    logic [11:0] col0, col2, col3;

    int nCmp = 0;
    int nBad = 0;

    assign data0 = constEn ? constData : {4'h0, addr0[11:0]};
    assign data1 = constEn ? constData : {4'h0, addr1[11:0]};
    assign data2 = constEn ? constData : {4'h0, addr2[11:0]};
    assign data3 = constEn ? constData : {4'h0, addr3[11:0]};
    assign col0  = {r0, g0, b0};
    assign col2  = {r2, g2, b2};
    assign col3  = {r3, g3, b3};

    pixel_window_gen u0 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCoordX(iCoordX), .iCoordY(iCoordY), .iData(data0),
        .iMode(iMode), .iBorder(iBorder), .oNext_Addr(addr0), .oRd_En(rd0),
        .oRed(r0), .oGreen(g0), .oBlue(b0), .oVIDEO_ON(vid0));

    pixel_window_gen #(.LOG2_SCALE(1)) u1 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCoordX(iCoordX), .iCoordY(iCoordY), .iData(data1),
        .iMode(iMode), .iBorder(iBorder), .oNext_Addr(addr1), .oRd_En(rd1),
        .oRed(r1), .oGreen(g1), .oBlue(b1), .oVIDEO_ON(vid1));

    pixel_window_gen #(.PIX_FMT(1)) u2 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCoordX(iCoordX), .iCoordY(iCoordY), .iData(data2),
        .iMode(iMode), .iBorder(iBorder), .oNext_Addr(addr2), .oRd_En(rd2),
        .oRed(r2), .oGreen(g2), .oBlue(b2), .oVIDEO_ON(vid2));

    pixel_window_gen #(.WIN_X0(64), .WIN_W(512)) u3 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCoordX(iCoordX), .iCoordY(iCoordY), .iData(data3),
        .iMode(iMode), .iBorder(iBorder), .oNext_Addr(addr3), .oRd_En(rd3),
        .oRed(r3), .oGreen(g3), .oBlue(b3), .oVIDEO_ON(vid3));

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present coordinates for one pixel, clock it, sample 1 ns after the edge.
    task automatic step(input int x, input int y);
        iCoordX = 10'(x);
        iCoordY = 10'(y);
        @(posedge iCLK);
        #1;
    endtask

    task automatic runLines(input int a, input int b);
        for (int y = a; y <= b; y++) step(639, y);
    endtask

    initial begin
        iRST_N    = 1'b0;
        iMode     = 2'b00;
        iBorder   = 12'h123;
        constEn   = 1'b0;
        constData = 16'h0000;
        iCoordX   = 10'd0;
        iCoordY   = 10'd0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_addr", 32'(addr0), 0);
        chk("reset_rd", 32'(rd0), 0);
        chk("reset_col", 32'(col0), 0);
        chk("reset_vid", 32'(vid0), 0);
        iRST_N = 1'b1;

        // Unsynced partial frame
        step(100, 100);
        chk("unsync_col", 32'(col0), 'h123);
        chk("unsync_vid", 32'(vid0), 0);
        chk("unsync_rd", 32'(rd0), 0);
        step(639, 479);

        // Frame 1: framebuffer mode
        runLines(0, 9);
        step(5, 10);
        chk("top_border_col", 32'(col0), 'h123);
        chk("top_border_vid", 32'(vid0), 0);
        runLines(10, 38);
        step(639, 39);
        chk("first_addr", 32'(addr0), 0);
        chk("first_rd", 32'(rd0), 1);
        chk("scale_first_rd", 32'(rd1), 1);
        chk("offset_win_rd_l40", 32'(rd3), 0);
        step(0, 40);
        chk("addr_0_40", 32'(addr0), 1);
        chk("col_0_40", 32'(col0), 'h000);
        chk("vid_0_40", 32'(vid0), 1);
        chk("scale_addr_0_40", 32'(addr1), 0);
        step(1, 40);
        chk("col_1_40", 32'(col0), 'h001);
        chk("scale_addr_1_40", 32'(addr1), 1);
        for (int x = 2; x <= 5; x++) step(x, 40);
        chk("col_5_40", 32'(col0), 'h005);
        step(638, 40);
        chk("scale_addr_638_40", 32'(addr1), 319);
        chk("addr_638_40", 32'(addr0), 639);
        step(639, 40);
        chk("col_639_40", 32'(col0), 'h27F);
        chk("addr_line41", 32'(addr0), 640);
        chk("scale_line41_repeat", 32'(addr1), 0);
        step(1, 41);
        chk("scale_addr_1_41", 32'(addr1), 1);
        step(639, 41);
        chk("scale_line42", 32'(addr1), 320);
        chk("addr_line42", 32'(addr0), 1280);
        runLines(42, 99);
        step(62, 100);
        step(63, 100);
        chk("offset_addr_63_100", 32'(addr3), 30720);
        chk("offset_rd_63_100", 32'(rd3), 1);
        step(574, 100);
        step(575, 100);
        chk("offset_rd_575_100", 32'(rd3), 0);
        chk("offset_addr_575_100", 32'(addr3), 0);
        step(576, 100);
        chk("offset_col_576_100", 32'(col3), 'h123);
        chk("offset_vid_576_100", 32'(vid3), 0);
        step(639, 100);
        runLines(101, 199);
        step(299, 200);
        iMode = 2'b01;
        step(300, 200);
        chk("midframe_mode_col", 32'(col0), 'h12C);
        chk("midframe_mode_vid", 32'(vid0), 1);
        step(639, 200);
        runLines(201, 438);
        constEn   = 1'b1;
        constData = 16'h0A5C;
        step(637, 439);
        chk("rgb444_decode", 32'(col0), 'hA5C);
        constData = 16'hF81F;
        step(638, 439);
        chk("rgb565_decode", 32'(col2), 'hF0F);
        chk("last_addr", 32'(addr0), 255999);
        chk("last_rd", 32'(rd0), 1);
        constEn = 1'b0;
        step(639, 439);
        chk("after_win_addr", 32'(addr0), 0);
        chk("after_win_rd", 32'(rd0), 0);
        runLines(440, 459);
        step(10, 460);
        chk("bottom_border_vid", 32'(vid0), 0);
        chk("bottom_border_col", 32'(col0), 'h123);
        runLines(460, 479);

        // Frame 2: colour bars
        runLines(0, 39);
        step(64, 40);
        chk("bar1_col", 32'(col0), 'h00F);
        chk("bar1_vid", 32'(vid0), 1);
        step(200, 40);
        chk("bar3_col", 32'(col0), 'h0FF);
        chk("offset_bar2_col", 32'(col3), 'h0F0);
        iMode = 2'b10;
        step(300, 40);
        chk("bar4_col", 32'(col0), 'hF00);
        step(639, 40);
        runLines(41, 479);

        // Frame 3: checkerboard
        runLines(0, 39);
        step(5, 40);
        chk("check_5_40", 32'(col0), 'h000);
        chk("check_vid", 32'(vid0), 1);
        step(16, 40);
        chk("check_16_40", 32'(col0), 'hFFF);
        step(639, 40);
        runLines(41, 55);
        step(0, 56);
        chk("check_0_56", 32'(col0), 'hFFF);
        step(16, 56);
        chk("check_16_56", 32'(col0), 'h000);
        iMode = 2'b11;
        step(639, 56);
        runLines(57, 479);

        // Frame 4: solid border, then reset mid-frame
        runLines(0, 99);
        step(5, 100);
        chk("solid_col", 32'(col0), 'h123);
        chk("solid_vid", 32'(vid0), 0);
        iCoordX = 10'd100;
        iCoordY = 10'd100;
        iRST_N  = 1'b0;
        #1;
        chk("async_rst_addr", 32'(addr0), 0);
        chk("async_rst_rd", 32'(rd0), 0);
        chk("async_rst_col", 32'(col0), 0);
        iMode  = 2'b00;
        iRST_N = 1'b1;
        step(101, 100);
        chk("post_rst_rd", 32'(rd0), 0);
        chk("post_rst_col", 32'(col0), 'h123);
        chk("post_rst_vid", 32'(vid0), 0);
        step(639, 100);
        chk("post_rst_line_rd", 32'(rd0), 0);
        runLines(101, 479);

        // Frame 5: resynchronised
        runLines(0, 38);
        step(639, 39);
        chk("resync_addr", 32'(addr0), 0);
        chk("resync_rd", 32'(rd0), 1);
        step(0, 40);
        chk("resync_col0", 32'(col0), 'h000);
        chk("resync_vid", 32'(vid0), 1);
        chk("resync_addr1", 32'(addr0), 1);
        step(1, 40);
        chk("resync_col1", 32'(col0), 'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
